data_mem_ctrl: RTL

Data-memory controller between the processor's Memory stage and a fixed-latency synchronous data SRAM. It accepts the single-word read/write request the Memory stage holds on `DataAddr`/`ReadData`/`WriteData`/`DataOut`. It runs the SRAM access over several cycles and stalls the pipeline through `DataWaitreq` until the result is ready. It returns read data on `DataIn` and flags out-of-range addresses.

---
 rtl/data_mem_ctrl_if.sv | 28 ++
 rtl/data_mem_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl_if.sv
// Processor Memory-stage and data-SRAM signal bundle for data_mem_ctrl.
// slave = controller view, master = processor plus SRAM view.
interface data_mem_ctrl_if #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_BITS = 12
);
  logic [WORD_SIZE-1:0]     DataAddr;
  logic                     ReadData;
  logic                     WriteData;
  logic [WORD_SIZE-1:0]     DataOut;
  logic [WORD_SIZE-1:0]     DataIn;
  logic                     DataWaitreq;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic                     mem_rd;
  logic                     mem_wr;
  logic [WORD_SIZE-1:0]     mem_wdata;
  logic [WORD_SIZE-1:0]     mem_rdata;

  modport slave (
    input  DataAddr, ReadData, WriteData, DataOut, mem_rdata,
    output DataIn, DataWaitreq, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output DataAddr, ReadData, WriteData, DataOut, mem_rdata,
    input  DataIn, DataWaitreq, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: stalls the Memory stage while a fixed-latency SRAM access runs.
// Optional DMC_WRITE_POST_EN adds a one-entry posted-write buffer.
module data_mem_ctrl #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_BITS = 12,
  parameter int MEM_LATENCY   = 2
) (
  input  logic            Clock,
  input  logic            Resetn,
  data_mem_ctrl_if.slave  bus,
  output logic            addr_err
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, DONE} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 addr_err_q, addr_err_d;
  logic                 req;
  logic                 in_range;
  logic                 wb_busy;

  assign req      = bus.ReadData | bus.WriteData;
  assign in_range = (bus.DataAddr >> MEM_ADDR_BITS) == '0;
  assign bus.DataIn = rdata_q;
  assign addr_err   = addr_err_q;

`ifdef DMC_WRITE_POST_EN
  logic                     wb_valid_q, wb_valid_d;
  logic [MEM_ADDR_BITS-1:0] wb_addr_q, wb_addr_d;
  logic [WORD_SIZE-1:0]     wb_data_q, wb_data_d;

  assign wb_busy = wb_valid_q;
`else
  assign wb_busy = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    addr_err_d      = addr_err_q;
    bus.DataWaitreq = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    bus.mem_addr    = bus.DataAddr[MEM_ADDR_BITS-1:0];
    bus.mem_wdata   = bus.DataOut;
`ifdef DMC_WRITE_POST_EN
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    // A buffered write always drains in the cycle right after it was accepted.
    if (wb_valid_q) begin
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = wb_addr_q;
      bus.mem_wdata = wb_data_q;
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (req) begin
          bus.DataWaitreq = 1'b1;
          if (bus.ReadData && wb_busy) begin
            state_d = IDLE;
          end else if (!in_range) begin
            // Out-of-range: no SRAM traffic, reads return zero, writes vanish.
            addr_err_d = 1'b1;
            if (bus.ReadData) rdata_d = '0;
            state_d = DONE;
          end else if (bus.ReadData) begin
            bus.mem_rd = 1'b1;
            cnt_d      = 4'(MEM_LATENCY - 1);
            state_d    = RD_WAIT;
          end else begin
`ifdef DMC_WRITE_POST_EN
            bus.DataWaitreq = 1'b0;
            wb_valid_d      = 1'b1;
            wb_addr_d       = bus.DataAddr[MEM_ADDR_BITS-1:0];
            wb_data_d       = bus.DataOut;
`else
            bus.mem_wr = 1'b1;
            state_d    = DONE;
`endif
          end
        end
      end
      RD_WAIT: begin
        bus.DataWaitreq = 1'b1;
        if (cnt_q == '0) begin
          rdata_d = bus.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // While held in reset the stall simply mirrors the request and nothing reaches the SRAM.
    if (!Resetn) begin
      bus.mem_rd      = 1'b0;
      bus.mem_wr      = 1'b0;
      bus.DataWaitreq = req;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
    end
  end

`ifdef DMC_WRITE_POST_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end
`endif

endmodule
